// File: rtl/q_frag_pkg.sv
// q_frag_pkg: shared FSM state encoding and counter-width helper for the Q_FRAG readback path
package q_frag_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FREEZE,
        S_CAPTURE,
        S_SHIFT,
        S_PARITY,
        S_DONE
    } state_t;

    // Wide enough to hold NUM_FRAGS itself, not just NUM_FRAGS-1
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/q_frag_piso_shift.sv
// q_frag_piso_shift: parallel-load, shift-right-on-enable snapshot register with running parity
// Ports: clk, rst (sync, active-high); load + d load the snapshot; shift moves it one bit
// toward q0; q0 is the bit currently at the output; par is the XOR of all bits shifted out
// since the last load.
module q_frag_piso_shift #(
    parameter int NUM_FRAGS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [NUM_FRAGS-1:0] d,
    output logic                 q0,
    output logic                 par
);

    logic [NUM_FRAGS-1:0] shadow;

    // Once every bit has been shifted out, par equals the even parity of the captured frame
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            par    <= 1'b0;
        end else if (load) begin
            shadow <= d;
            par    <= 1'b0;
        end else if (shift) begin
            shadow <= shadow >> 1;
            par    <= par ^ shadow[0];
        end
    end

    assign q0 = shadow[0];

endmodule

// File: rtl/q_frag_readback.sv
// q_frag_readback: freezes Q_FRAG enables, snapshots QZ_IN and streams it out LSB first over valid/ready
// Ports: QCK clock; QRT sync active-high reset; CAP_REQ level capture request (IDLE only);
// QZ_IN fragment QZ outputs; QEN_FREEZE holds array QEN low; SDO/SDO_VALID/SDO_READY/SDO_LAST
// serial link; CAP_ACK one-cycle frame-done pulse; BUSY high outside IDLE.
// Build option: define Q_FRAG_READBACK_PARITY_EN to append an even-parity bit to each frame.
module q_frag_readback
    import q_frag_pkg::*;
#(
    parameter int NUM_FRAGS = 16
) (
    input  logic                 QCK,
    input  logic                 QRT,
    input  logic                 CAP_REQ,
    input  logic [NUM_FRAGS-1:0] QZ_IN,
    output logic                 QEN_FREEZE,
    output logic                 SDO,
    output logic                 SDO_VALID,
    input  logic                 SDO_READY,
    output logic                 SDO_LAST,
    output logic                 CAP_ACK,
    output logic                 BUSY
);

    localparam int CNT_W = cnt_w(NUM_FRAGS);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             load, shift, fire, q0, par, last_data;

    q_frag_piso_shift #(.NUM_FRAGS(NUM_FRAGS)) u_piso (
        .clk  (QCK),
        .rst  (QRT),
        .load (load),
        .shift(shift),
        .d    (QZ_IN),
        .q0   (q0),
        .par  (par)
    );

    assign fire      = SDO_VALID && SDO_READY;
    assign load      = state == S_CAPTURE;
    assign shift     = state == S_SHIFT && fire;
    assign last_data = cnt == CNT_W'(1);

    always_ff @(posedge QCK) begin
        if (QRT) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (load)
                cnt <= CNT_W'(NUM_FRAGS);
            else if (shift)
                cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    state_nx = CAP_REQ ? S_FREEZE : S_IDLE;
            S_FREEZE:  state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_SHIFT;
`ifdef Q_FRAG_READBACK_PARITY_EN
            S_SHIFT:   state_nx = (shift && last_data) ? S_PARITY : S_SHIFT;
            S_PARITY:  state_nx = fire ? S_DONE : S_PARITY;
`else
            S_SHIFT:   state_nx = (shift && last_data) ? S_DONE : S_SHIFT;
`endif
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // S_PARITY is unreachable without the parity build, so its output terms vanish there
    assign QEN_FREEZE = state == S_FREEZE || state == S_CAPTURE;
    assign SDO_VALID  = state == S_SHIFT || state == S_PARITY;
    assign SDO        = (state == S_SHIFT && q0) || (state == S_PARITY && par);
    assign CAP_ACK    = state == S_DONE;
    assign BUSY       = state != S_IDLE;
`ifdef Q_FRAG_READBACK_PARITY_EN
    assign SDO_LAST   = state == S_PARITY;
`else
    assign SDO_LAST   = state == S_SHIFT && last_data;
`endif

endmodule

// File: tb/tb_q_frag_readback.sv
// tb_q_frag_readback: randomized and directed frame checks against a queue-based reference model
module tb_q_frag_readback;

    localparam int N = 16;
`ifdef Q_FRAG_READBACK_PARITY_EN
    localparam int NB = N + 1;
`else
    localparam int NB = N;
`endif

    logic         QCK = 1'b0;
    logic         QRT, CAP_REQ, SDO_READY;
    logic [N-1:0] QZ_IN;
    logic         QEN_FREEZE, SDO, SDO_VALID, SDO_LAST, CAP_ACK, BUSY;
    int           checks = 0;
    int           fails = 0;

    always #5 QCK = ~QCK;

    q_frag_readback #(.NUM_FRAGS(N)) dut (
        .QCK       (QCK),
        .QRT       (QRT),
        .CAP_REQ   (CAP_REQ),
        .QZ_IN     (QZ_IN),
        .QEN_FREEZE(QEN_FREEZE),
        .SDO       (SDO),
        .SDO_VALID (SDO_VALID),
        .SDO_READY (SDO_READY),
        .SDO_LAST  (SDO_LAST),
        .CAP_ACK   (CAP_ACK),
        .BUSY      (BUSY)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge QCK);
        #1;
    endtask

    // mode: 0 ready always, 1 ready toggles, 2 random ready
    // abort_at >= 0 resets the DUT once that many bits have been accepted
    // disturb zeroes QZ_IN and pulses CAP_REQ mid-stream
    task automatic frame(input logic [N-1:0] qz, input int mode, input int abort_at, input bit disturb);
        bit   exp_q[$];
        int   idx = 0;
        int   cyc = 0;
        bit   prev_stall = 0;
        bit   r;
        logic prev_sdo = 0, prev_last = 0;
        for (int i = 0; i < N; i++) exp_q.push_back(qz[i]);
        if (NB > N) exp_q.push_back(^qz);
        QZ_IN = qz; CAP_REQ = 1; SDO_READY = 0;
        step;
        check("freeze_1", {BUSY, QEN_FREEZE, SDO_VALID}, 3'b110);
        CAP_REQ = 0;
        step;
        check("freeze_2", {BUSY, QEN_FREEZE, SDO_VALID}, 3'b110);
        step;
        while (idx < NB && cyc < 20 * NB) begin
            if (abort_at >= 0 && idx == abort_at) begin
                QRT = 1; SDO_READY = 0;
                step;
                QRT = 0;
                check("abort", {SDO_VALID, BUSY, QEN_FREEZE, CAP_ACK}, 4'b0);
                step;
                check("abort_idle", {BUSY, CAP_ACK}, 2'b0);
                return;
            end
            r = mode == 0 ? 1'b1 : mode == 1 ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            check("valid", {SDO_VALID, QEN_FREEZE, BUSY}, 3'b101);
            if (prev_stall) begin
                check("stall_sdo", SDO, prev_sdo);
                check("stall_last", SDO_LAST, prev_last);
            end
            if (disturb) begin
                CAP_REQ = idx == 4;
                if (idx == 4) QZ_IN = '0;
            end
            if (r) begin
                check("sdo", SDO, exp_q[idx]);
                check("last", SDO_LAST, idx == NB - 1);
                idx++;
            end
            prev_stall = !r; prev_sdo = SDO; prev_last = SDO_LAST;
            SDO_READY = r;
            step;
            cyc++;
        end
        check("frame_done", idx, NB);
        SDO_READY = 0; CAP_REQ = 0;
        check("ack", {CAP_ACK, SDO_VALID, BUSY}, 3'b101);
        if (mode == 0) check("cycles", cyc, NB);
        step;
        check("idle", {BUSY, CAP_ACK, QEN_FREEZE, SDO_VALID}, 4'b0);
        step;
        check("no_refire", {BUSY, CAP_ACK}, 2'b0);
    endtask

    initial begin
        QRT = 1; CAP_REQ = 1; SDO_READY = 0; QZ_IN = N'($urandom);
        step;
        step;
        check("reset", {QEN_FREEZE, SDO, SDO_VALID, SDO_LAST, CAP_ACK, BUSY}, 6'b0);
        QRT = 0; CAP_REQ = 0;
        step;
        check("reset_idle", {QEN_FREEZE, SDO_VALID, CAP_ACK, BUSY}, 4'b0);
        frame(16'hA5C3, 0, -1, 0);
        frame(16'hA5C3, 1, -1, 0);
        frame(16'hA5C3, 0, -1, 1);
        frame(N'($urandom), 0, 5, 0);
        frame(16'hA5C3, 0, -1, 0);
        frame(16'h0001, 0, -1, 0);
        frame(16'h0003, 0, -1, 0);
        frame(16'hFFFF, 1, -1, 0);
        for (int k = 0; k < 10; k++) frame(N'($urandom), 2, -1, 0);
        frame(N'($urandom), 2, 3, 0);
        frame(N'($urandom), 2, -1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
